// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_res_valid;
  logic [31:0] imem_res_data;

  modport master (output imem_req_valid, output imem_req_addr, input imem_req_ready,
                  input imem_res_valid, input imem_res_data);
  modport slave  (input imem_req_valid, input imem_req_addr, output imem_req_ready,
                  output imem_res_valid, output imem_res_data);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, in-order imem requests, instruction buffer, redirect/drop handling.
// Optional same-cycle response-to-decode bypass enabled by defining FETCH_BYPASS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0200,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  imem,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          stall,
  output logic          dec_valid,
  output logic [31:0]   dec_inst,
  output logic [31:0]   dec_pc
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  logic [31:0]                  r_pc;
  logic [31:0]                  r_rsp_pc;
  logic [CW-1:0]                r_outst;
  logic [CW-1:0]                r_drop;
  logic [CW-1:0]                r_count;
  logic [PW-1:0]                r_wptr, r_rptr;
  logic [FIFO_DEPTH-1:0][31:0]  r_inst;
  logic [FIFO_DEPTH-1:0][31:0]  r_ipc;

  logic [CW:0]   w_inflight;
  logic          w_req_valid, w_accept, w_res_ok, w_take, w_bypass, w_push, w_pop;
  logic [CW-1:0] w_outst_after_res;
  logic          w_unused;

  assign w_unused   = ^redirect_pc[1:0];
  assign w_inflight = {1'b0, r_outst} + {1'b0, r_count};

  // Dropped responses still occupy a slot until they return, so they throttle requests too.
  assign w_req_valid = reset && !redirect_valid && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign w_accept    = w_req_valid && imem.imem_req_ready;
  assign w_res_ok    = imem.imem_res_valid && (r_outst != '0);
  assign w_take      = w_res_ok && (r_drop == '0) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
  assign w_bypass    = reset && w_take && (r_count == '0) && !stall;
`else
  assign w_bypass    = 1'b0;
`endif
  assign w_push      = w_take && !w_bypass;
  assign w_pop       = (r_count != '0) && !stall && !redirect_valid;
  assign w_outst_after_res = r_outst - CW'(w_res_ok);

  assign imem.imem_req_valid = w_req_valid;
  assign imem.imem_req_addr  = r_pc;

  assign dec_valid = reset && ((r_count != '0) || w_bypass);
  assign dec_inst  = !reset ? '0 : (w_bypass ? imem.imem_res_data : r_inst[r_rptr]);
  assign dec_pc    = !reset ? '0 : (w_bypass ? r_rsp_pc           : r_ipc[r_rptr]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= '0;
      r_drop   <= '0;
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_inst   <= '0;
      r_ipc    <= '0;
    end else begin
      r_outst <= w_outst_after_res + CW'(w_accept);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path; reload, never accumulate.
        r_pc     <= {redirect_pc[31:2], 2'b00};
        r_rsp_pc <= {redirect_pc[31:2], 2'b00};
        r_drop   <= w_outst_after_res;
        r_count  <= '0;
        r_wptr   <= '0;
        r_rptr   <= '0;
      end else begin
        if (w_accept)                 r_pc     <= r_pc + 32'd4;
        if (w_res_ok && r_drop != '0) r_drop   <= r_drop - CW'(1);
        if (w_take)                   r_rsp_pc <= r_rsp_pc + 32'd4;
        if (w_push) begin
          r_inst[r_wptr] <= imem.imem_res_data;
          r_ipc[r_wptr]  <= r_rsp_pc;
          r_wptr         <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
        end
        if (w_pop) r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule
